// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the MEM-stage data-memory arbiter.
// owner_t records which requester last held the memory port.
package dmem_arbiter_pkg;

  localparam int DMEM_DEPTH = 32;
  localparam int DMEM_AW    = 5;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_t;

  // Word addresses at or beyond the memory size are rejected, never aliased.
  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned depth);
    return addr >= depth;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the loader, the data memory and the arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface dmem_arbiter_if #(
  parameter int AW = dmem_arbiter_pkg::DMEM_AW
);
  logic          cpu_rd;
  logic          cpu_wr;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_rvalid;
  logic          cpu_stall;

  logic          ld_req;
  logic          ld_we;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt;
  logic [31:0]   ld_rdata;
  logic          ld_rvalid;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic          addr_err;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_rvalid, cpu_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rdata, ld_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output addr_err
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_rvalid, cpu_stall,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rdata, ld_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  addr_err
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 is the CPU, bit 1 the loader.
// On a conflict the requester that did not own the last grant wins.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  owner_t r_last_owner;

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last_owner == OWN_LD) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Reset to LD so the CPU wins the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_owner <= OWN_LD;
    end else if (|o_gnt) begin
      r_last_owner <= o_gnt[0] ? OWN_CPU : OWN_LD;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the loader,
// range-checks addresses and routes 1-cycle read returns back to the issuer.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  logic        w_cpu_act;
  logic [1:0]  w_req;
  logic [1:0]  w_gnt;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_we;
  logic        w_oor;
  logic        w_acc_ok;
  logic        w_rd_cpu_p0;
  logic        w_rd_ld_p0;
  logic        w_rd_err_p0;
  logic        w_cpu_vld_p1;
  logic        w_ld_vld_p1;
  logic [31:0] w_ret_p1;

  logic        r_rd_pend_cpu_p1;
  logic        r_rd_pend_ld_p1;
  logic        r_rd_pend_err_p1;
  logic        r_addr_err;
  logic [31:0] r_cpu_rdata_p1;
  logic [31:0] r_ld_rdata_p1;

  // Write wins over read when the MEM stage raises both.
  assign w_cpu_act = bus.cpu_rd | bus.cpu_wr;
  assign w_req     = rst ? 2'b00 : {bus.ld_req, w_cpu_act};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    if (w_gnt[0]) begin
      w_sel_addr  = bus.cpu_addr;
      w_sel_wdata = bus.cpu_wdata;
      w_sel_we    = bus.cpu_wr;
    end else if (w_gnt[1]) begin
      w_sel_addr  = bus.ld_addr;
      w_sel_wdata = bus.ld_wdata;
      w_sel_we    = bus.ld_we;
    end
  end

  assign w_oor    = addr_oor(w_sel_addr, DEPTH);
  assign w_acc_ok = (|w_gnt) & ~w_oor;

  assign bus.mem_en    = w_acc_ok;
  assign bus.mem_we    = w_acc_ok & w_sel_we;
  assign bus.mem_addr  = w_sel_addr[AW-1:0];
  assign bus.mem_wdata = w_sel_wdata;

  assign bus.cpu_stall = w_cpu_act & ~w_gnt[0];
  assign bus.ld_gnt    = w_gnt[1];

  assign w_rd_cpu_p0 = w_gnt[0] & ~bus.cpu_wr;
  assign w_rd_ld_p0  = w_gnt[1] & ~bus.ld_we;
  assign w_rd_err_p0 = (w_rd_cpu_p0 | w_rd_ld_p0) & w_oor;

  // ---- p0 -> p1: issue registered, memory data returns this cycle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend_cpu_p1 <= 1'b0;
      r_rd_pend_ld_p1  <= 1'b0;
      r_rd_pend_err_p1 <= 1'b0;
      r_addr_err       <= 1'b0;
      r_cpu_rdata_p1   <= '0;
      r_ld_rdata_p1    <= '0;
    end else begin
      r_rd_pend_cpu_p1 <= w_rd_cpu_p0;
      r_rd_pend_ld_p1  <= w_rd_ld_p0;
      r_rd_pend_err_p1 <= w_rd_err_p0;
      if ((|w_gnt) & w_oor) r_addr_err <= 1'b1;
      if (w_cpu_vld_p1) r_cpu_rdata_p1 <= w_ret_p1;
      if (w_ld_vld_p1)  r_ld_rdata_p1  <= w_ret_p1;
    end
  end

  // A return landing in a reset cycle is dropped.
  assign w_cpu_vld_p1 = r_rd_pend_cpu_p1 & ~rst;
  assign w_ld_vld_p1  = r_rd_pend_ld_p1 & ~rst;
  assign w_ret_p1     = r_rd_pend_err_p1 ? 32'd0 : bus.mem_rdata;

  assign bus.cpu_rvalid = w_cpu_vld_p1;
  assign bus.ld_rvalid  = w_ld_vld_p1;
  assign bus.cpu_rdata  = w_cpu_vld_p1 ? w_ret_p1 : r_cpu_rdata_p1;
  assign bus.ld_rdata   = w_ld_vld_p1 ? w_ret_p1 : r_ld_rdata_p1;
  assign bus.addr_err   = r_addr_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: single-cycle vector table, directed multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(5)) bus ();

  dmem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous-read memory; contents restore to mem[i] = i during reset.
  logic [31:0] tb_mem [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) tb_mem[i] <= 32'(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= tb_mem[bus.mem_addr];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ldd);
    bus.cpu_rd = cr; bus.cpu_wr = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.ld_req = lr; bus.ld_we  = lw; bus.ld_addr  = la; bus.ld_wdata  = ldd;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        lr, lw;
    logic [31:0] la, ld;
    logic        e_stall, e_gnt, e_en, e_we;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  localparam logic [31:0] CD = 32'hAAAA_0001;
  localparam logic [31:0] LD = 32'hBBBB_0002;

  vec_t vecs [10];

  // Reference model state for the randomized run.
  logic [31:0] ref_mem [32];
  logic        m_last_ld, m_err;
  logic        e_crv, e_lrv;
  logic [31:0] e_crd, e_lrd;

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return $urandom | 32'h20;
    return 32'($urandom_range(0, 31));
  endfunction

  initial begin
    idle();
    bus.cpu_rd = 1'b1;
    bus.ld_req = 1'b1;
    // Reset state, with requests held during reset.
    tick();
    @(negedge clk);
    chk("rst_stall",  32'(bus.cpu_stall), 32'd1);
    chk("rst_ld_gnt", 32'(bus.ld_gnt), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_crv",    32'(bus.cpu_rvalid), 32'd0);
    chk("rst_lrv",    32'(bus.ld_rvalid), 32'd0);
    chk("rst_crd",    bus.cpu_rdata, 32'd0);
    chk("rst_lrd",    bus.ld_rdata, 32'd0);
    chk("rst_err",    32'(bus.addr_err), 32'd0);

    // Single-cycle arbitration vectors, each from a fresh reset (last owner LD).
    vecs[0] = '{1'b0, 1'b0, 32'd0,  CD, 1'b0, 1'b0, 32'd0,        LD, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'd0};
    vecs[1] = '{1'b1, 1'b0, 32'd7,  CD, 1'b0, 1'b0, 32'd0,        LD, 1'b0, 1'b0, 1'b1, 1'b0, 32'd7,  32'd0};
    vecs[2] = '{1'b0, 1'b1, 32'd3,  CD, 1'b0, 1'b0, 32'd0,        LD, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3,  CD};
    vecs[3] = '{1'b0, 1'b0, 32'd0,  CD, 1'b1, 1'b0, 32'd9,        LD, 1'b0, 1'b1, 1'b1, 1'b0, 32'd9,  32'd0};
    vecs[4] = '{1'b0, 1'b0, 32'd0,  CD, 1'b1, 1'b1, 32'd4,        LD, 1'b0, 1'b1, 1'b1, 1'b1, 32'd4,  LD};
    vecs[5] = '{1'b1, 1'b0, 32'd2,  CD, 1'b1, 1'b1, 32'd4,        LD, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2,  32'd0};
    vecs[6] = '{1'b1, 1'b1, 32'd6,  CD, 1'b0, 1'b0, 32'd0,        LD, 1'b0, 1'b0, 1'b1, 1'b1, 32'd6,  CD};
    vecs[7] = '{1'b1, 1'b0, 32'd32, CD, 1'b0, 1'b0, 32'd0,        LD, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'd0};
    vecs[8] = '{1'b0, 1'b0, 32'd0,  CD, 1'b1, 1'b0, 32'hFFFFFFFF, LD, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  32'd0};
    vecs[9] = '{1'b0, 1'b1, 32'd31, CD, 1'b1, 1'b0, 32'd8,        LD, 1'b0, 1'b0, 1'b1, 1'b1, 32'd31, CD};

    for (int i = 0; i < 10; i++) begin
      do_reset();
      drv(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].lr, vecs[i].lw, vecs[i].la, vecs[i].ld);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_gnt", i),   32'(bus.ld_gnt),    32'(vecs[i].e_gnt));
      chk($sformatf("vec%0d_en", i),    32'(bus.mem_en),    32'(vecs[i].e_en));
      chk($sformatf("vec%0d_we", i),    32'(bus.mem_we),    32'(vecs[i].e_we));
      if (vecs[i].e_en) chk($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), vecs[i].e_addr);
      if (vecs[i].e_we) chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, vecs[i].e_wdata);
      tick();
    end

    // CPU-only read of address 7.
    do_reset();
    drv(1'b1, 1'b0, 32'd7, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("a_en", 32'(bus.mem_en), 32'd1);
    chk("a_addr", 32'(bus.mem_addr), 32'd7);
    chk("a_stall", 32'(bus.cpu_stall), 32'd0);
    tick(); idle();
    @(negedge clk);
    chk("a_crv", 32'(bus.cpu_rvalid), 32'd1);
    chk("a_crd", bus.cpu_rdata, 32'd7);
    tick();

    // Conflict after reset, then loader alone next cycle.
    do_reset();
    drv(1'b0, 1'b1, 32'd3, 32'hAA, 1'b1, 1'b1, 32'd4, 32'hBB);
    @(negedge clk);
    chk("b_gnt0", 32'(bus.ld_gnt), 32'd0);
    chk("b_stall0", 32'(bus.cpu_stall), 32'd0);
    chk("b_addr0", 32'(bus.mem_addr), 32'd3);
    tick();
    drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd4, 32'hBB);
    @(negedge clk);
    chk("b_gnt1", 32'(bus.ld_gnt), 32'd1);
    chk("b_stall1", 32'(bus.cpu_stall), 32'd0);
    chk("b_addr1", 32'(bus.mem_addr), 32'd4);
    tick();
    // Both held four cycles: CPU, LD, CPU, LD.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv(1'b0, 1'b1, 32'd3, 32'hAA, 1'b1, 1'b1, 32'd4, 32'hBB);
      @(negedge clk);
      chk($sformatf("b_alt%0d_gnt", k), 32'(bus.ld_gnt), 32'(k % 2));
      chk($sformatf("b_alt%0d_stall", k), 32'(bus.cpu_stall), 32'(k % 2));
      tick();
    end

    // Stall hold: CPU owns last grant, both read.
    do_reset();
    drv(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    drv(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
    @(negedge clk);
    chk("c_stall0", 32'(bus.cpu_stall), 32'd1);
    chk("c_gnt0", 32'(bus.ld_gnt), 32'd1);
    tick();
    drv(1'b1, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("c_stall1", 32'(bus.cpu_stall), 32'd0);
    chk("c_addr1", 32'(bus.mem_addr), 32'd1);
    chk("c_lrv1", 32'(bus.ld_rvalid), 32'd1);
    chk("c_lrd1", bus.ld_rdata, 32'd2);
    chk("c_crv1", 32'(bus.cpu_rvalid), 32'd0);
    tick(); idle();
    @(negedge clk);
    chk("c_crv2", 32'(bus.cpu_rvalid), 32'd1);
    chk("c_crd2", bus.cpu_rdata, 32'd1);
    chk("c_lrv2", 32'(bus.ld_rvalid), 32'd0);
    tick();

    // Out-of-range read returns zero even with stale memory data present.
    do_reset();
    drv(1'b1, 1'b0, 32'd9, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    drv(1'b1, 1'b0, 32'd32, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("d_en", 32'(bus.mem_en), 32'd0);
    chk("d_stall", 32'(bus.cpu_stall), 32'd0);
    chk("d_err0", 32'(bus.addr_err), 32'd0);
    tick(); idle();
    @(negedge clk);
    chk("d_err1", 32'(bus.addr_err), 32'd1);
    chk("d_crv", 32'(bus.cpu_rvalid), 32'd1);
    chk("d_crd", bus.cpu_rdata, 32'd0);
    tick();
    drv(1'b1, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(); idle();
    @(negedge clk);
    chk("d_crd2", bus.cpu_rdata, 32'd1);
    chk("d_err2", 32'(bus.addr_err), 32'd1);
    tick();

    // Loader write followed directly by CPU read of the same word.
    do_reset();
    drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd5, 32'h1234);
    @(negedge clk);
    chk("e_gnt", 32'(bus.ld_gnt), 32'd1);
    tick();
    drv(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(); idle();
    @(negedge clk);
    chk("e_crv", 32'(bus.cpu_rvalid), 32'd1);
    chk("e_crd", bus.cpu_rdata, 32'h1234);
    chk("e_mem5", tb_mem[5], 32'h1234);
    tick();

    // Reset lands on the cycle after a CPU read issues.
    do_reset();
    drv(1'b1, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    idle(); rst = 1'b1;
    @(negedge clk);
    chk("f_crv1", 32'(bus.cpu_rvalid), 32'd0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("f_crv2", 32'(bus.cpu_rvalid), 32'd0);
    tick();
    drv(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
    @(negedge clk);
    chk("f_gnt", 32'(bus.ld_gnt), 32'd0);
    chk("f_stall", 32'(bus.cpu_stall), 32'd0);
    tick();

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i);
    m_last_ld = 1'b1; m_err = 1'b0; e_crv = 1'b0; e_lrv = 1'b0; e_crd = '0; e_lrd = '0;
    for (int n = 0; n < 600; n++) begin
      logic r, cr, cw, lr, lw, c_act, win_c, win_l, any, oor, g_we, x_en;
      logic [31:0] ca, cd, la, ldd, g_addr, g_wd, rd_val;
      r   = ($urandom_range(0, 59) == 0);
      cr  = ($urandom_range(0, 2) == 0);
      cw  = ($urandom_range(0, 3) == 0);
      lr  = ($urandom_range(0, 1) == 0);
      lw  = ($urandom_range(0, 1) == 0);
      ca  = pick_addr(); la = pick_addr();
      cd  = $urandom;    ldd = $urandom;
      rst = r;
      drv(cr, cw, ca, cd, lr, lw, la, ldd);

      c_act = cr | cw;
      win_c = 1'b0; win_l = 1'b0;
      if (!r) begin
        if (c_act && lr) begin
          win_c = m_last_ld;
          win_l = !m_last_ld;
        end else begin
          win_c = c_act;
          win_l = lr;
        end
      end
      any    = win_c | win_l;
      g_addr = win_c ? ca : la;
      g_wd   = win_c ? cd : ldd;
      g_we   = win_c ? cw : lw;
      oor    = (g_addr >= 32);
      x_en   = any && !oor;

      @(negedge clk);
      chk("rnd_stall", 32'(bus.cpu_stall), 32'(c_act && !win_c));
      chk("rnd_gnt",   32'(bus.ld_gnt), 32'(win_l));
      chk("rnd_en",    32'(bus.mem_en), 32'(x_en));
      chk("rnd_we",    32'(bus.mem_we), 32'(x_en && g_we));
      if (x_en) chk("rnd_addr", 32'(bus.mem_addr), g_addr);
      if (x_en && g_we) chk("rnd_wdata", bus.mem_wdata, g_wd);
      chk("rnd_crv", 32'(bus.cpu_rvalid), 32'(e_crv && !r));
      chk("rnd_lrv", 32'(bus.ld_rvalid), 32'(e_lrv && !r));
      if (e_crv && !r) chk("rnd_crd", bus.cpu_rdata, e_crd);
      if (e_lrv && !r) chk("rnd_lrd", bus.ld_rdata, e_lrd);
      chk("rnd_err", 32'(bus.addr_err), 32'(m_err));

      if (r) begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i);
        m_last_ld = 1'b1; m_err = 1'b0; e_crv = 1'b0; e_lrv = 1'b0;
      end else begin
        rd_val = oor ? 32'd0 : ref_mem[g_addr[4:0]];
        e_crv = win_c && !cw;
        e_lrv = win_l && !lw;
        if (e_crv) e_crd = rd_val;
        if (e_lrv) e_lrd = rd_val;
        if (any && oor) m_err = 1'b1;
        if (x_en && g_we) ref_mem[g_addr[4:0]] = g_wd;
        if (any) m_last_ld = win_l;
      end
      tick();
    end
    rst = 1'b0;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
